// File: rtl/epp_slave.sv
// EPP slave: synchronizes the asynchronous EPP strobes onto clk_in and serves a small register
// file (scratch, LED, heartbeat counter, ID) to the host.
module epp_slave #(
  parameter logic [7:0]  ID_VALUE = 8'hA5,
  parameter int unsigned HB_WIDTH = 8
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       slow_clk,
  input  logic       astb_n,
  input  logic       dstb_n,
  input  logic       wr_n,
  input  logic [7:0] db_i,
  output logic [7:0] db_o,
  output logic       db_oe,
  output logic       wait_o,
  output logic [7:0] led_o
);

  typedef enum logic [2:0] {StIdle, StAddrWr, StAddrRd, StDataWr, StDataRd, StHold} state_e;

  state_e              state_q, state_d;
  logic [2:0]          strb_s1_q, strb_s2_q;  // {wr_n, dstb_n, astb_n}
  logic [2:0]          sc_q;                  // {history, sync2, sync1} of slow_clk
  logic [1:0]          sync_vld_q;
  logic                arm_q;
  logic                cyc_addr_q, cyc_rd_q;
  logic [7:0]          addr_q, scratch_q, led_q, rd_data_q;
  logic [HB_WIDTH-1:0] hb_cnt_q;
  logic [7:0]          hb_ext, reg_rd, rd_sel;
  logic                astb_s, dstb_s, wr_s, start, addr_we, data_we;

  assign astb_s = strb_s2_q[0];
  assign dstb_s = strb_s2_q[1];
  assign wr_s   = strb_s2_q[2];

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      strb_s1_q  <= 3'b111;
      strb_s2_q  <= 3'b111;
      sc_q       <= 3'b000;
      sync_vld_q <= 2'b00;
      hb_cnt_q   <= '0;
    end else begin
      strb_s1_q  <= {wr_n, dstb_n, astb_n};
      strb_s2_q  <= strb_s1_q;
      sc_q       <= {sc_q[1:0], slow_clk};
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      if (sc_q[1] && !sc_q[2]) hb_cnt_q <= hb_cnt_q + HB_WIDTH'(1);
    end
  end

  // A cycle may only start once both synced strobes were genuinely observed high, so
  // a strobe held low across reset or left low after a cycle is not replayed.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      arm_q <= 1'b0;
    end else if (state_q != StIdle) begin
      arm_q <= 1'b0;
    end else if (sync_vld_q[1] && astb_s && dstb_s) begin
      arm_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (arm_q) begin
          if (!astb_s)      state_d = wr_s ? StAddrRd : StAddrWr;
          else if (!dstb_s) state_d = wr_s ? StDataRd : StDataWr;
        end
      end
      StAddrWr, StAddrRd, StDataWr, StDataRd: state_d = StHold;
      StHold: if (cyc_addr_q ? astb_s : dstb_s) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wait_o  = (state_q != StIdle);
    db_oe   = (state_q inside {StAddrRd, StDataRd}) || (state_q == StHold && cyc_rd_q);
    db_o    = db_oe ? rd_data_q : 8'h00;
    addr_we = (state_q == StAddrWr);
    data_we = (state_q == StDataWr);
    start   = (state_q == StIdle) && (state_d != StIdle);
  end

  always_comb begin
    hb_ext = '0;
    hb_ext[HB_WIDTH-1:0] = hb_cnt_q;
    unique case (addr_q)
      8'h00:   reg_rd = scratch_q;
      8'h01:   reg_rd = led_q;
      8'h02:   reg_rd = hb_ext;
      8'h03:   reg_rd = ID_VALUE;
      default: reg_rd = 8'h00;
    endcase
    rd_sel = (state_d == StAddrRd) ? addr_q : reg_rd;
  end

  // Read data is captured when the cycle starts so db_o stays stable while hb_cnt keeps counting.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cyc_addr_q <= 1'b0;
      cyc_rd_q   <= 1'b0;
      rd_data_q  <= 8'h00;
      addr_q     <= 8'h00;
      scratch_q  <= 8'h00;
      led_q      <= 8'h00;
    end else begin
      if (start) begin
        cyc_addr_q <= (state_d inside {StAddrWr, StAddrRd});
        cyc_rd_q   <= wr_s;
        rd_data_q  <= rd_sel;
      end
      if (addr_we) addr_q <= db_i;
      if (data_we) begin
        if (addr_q == 8'h00) scratch_q <= db_i;
        if (addr_q == 8'h01) led_q     <= db_i;
      end
    end
  end

  assign led_o = led_q;

endmodule

// File: tb/tb_epp_slave.sv
// Directed bench for epp_slave: host EPP cycles, register map, heartbeat wrap and async reset.
module tb_epp_slave;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic       slow_clk = 1'b0;
  logic       astb_n = 1'b1;
  logic       dstb_n = 1'b1;
  logic       wr_n = 1'b1;
  logic [7:0] db_i = 8'h00;
  logic [7:0] db_o;
  logic       db_oe;
  logic       wait_o;
  logic [7:0] led_o;

  int errors = 0;
  int checks = 0;

  epp_slave #(.ID_VALUE(8'hA5), .HB_WIDTH(8)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .slow_clk (slow_clk),
    .astb_n   (astb_n),
    .dstb_n   (dstb_n),
    .wr_n     (wr_n),
    .db_i     (db_i),
    .db_o     (db_o),
    .db_oe    (db_oe),
    .wait_o   (wait_o),
    .led_o    (led_o)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete host cycle; lat/rel count clk_in edges from strobe edge to wait_o change.
  task automatic host_cycle(input bit is_addr, input bit is_wr, input logic [7:0] data,
                            output logic [7:0] rd, output logic oe, output int lat,
                            output int rel);
    @(negedge clk_in);
    wr_n = !is_wr;
    db_i = data;
    @(negedge clk_in);
    if (is_addr) astb_n = 1'b0;
    else         dstb_n = 1'b0;
    lat = 0;
    while (!wait_o && lat < 20) begin
      @(posedge clk_in); #1;
      lat++;
    end
    @(negedge clk_in);
    rd = db_o;
    oe = db_oe;
    if (is_addr) astb_n = 1'b1;
    else         dstb_n = 1'b1;
    rel = 0;
    while (wait_o && rel < 20) begin
      @(posedge clk_in); #1;
      rel++;
    end
    repeat (3) @(negedge clk_in);
    wr_n = 1'b1;
  endtask

  initial begin
    logic [7:0] rd;
    logic       oe;
    int         lat, rel, n;

    #2;
    chk("rst_wait", wait_o, 1'b0);
    chk("rst_oe", db_oe, 1'b0);
    chk("rst_db_o", db_o, 8'h00);
    chk("rst_led", led_o, 8'h00);
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_in);

    // LED write with latency checks
    host_cycle(1'b1, 1'b1, 8'h01, rd, oe, lat, rel);
    chk("addr_wr_lat", lat, 3);
    host_cycle(1'b0, 1'b1, 8'h3C, rd, oe, lat, rel);
    chk("data_wr_lat", lat, 3);
    chk("led_3c", led_o, 8'h3C);

    // ID read
    host_cycle(1'b1, 1'b1, 8'h03, rd, oe, lat, rel);
    host_cycle(1'b0, 1'b0, 8'h00, rd, oe, lat, rel);
    chk("id_rd_lat", lat, 3);
    chk("id_oe", oe, 1'b1);
    chk("id_val", rd, 8'hA5);
    chk("id_release_2to3", (rel >= 2 && rel <= 3), 1'b1);
    chk("idle_db_o_zero", {db_oe, db_o}, 9'h000);

    // Heartbeat: 260 rising edges wrap an 8-bit counter to 4
    for (int i = 0; i < 260; i++) begin
      slow_clk = 1'b1;
      repeat (3) @(negedge clk_in);
      slow_clk = 1'b0;
      repeat (3) @(negedge clk_in);
    end
    host_cycle(1'b1, 1'b1, 8'h02, rd, oe, lat, rel);
    host_cycle(1'b0, 1'b0, 8'h00, rd, oe, lat, rel);
    chk("hb_wrap", rd, 8'h04);

    // Both strobes together: address write wins
    @(negedge clk_in);
    wr_n = 1'b0;
    db_i = 8'h02;
    @(negedge clk_in);
    astb_n = 1'b0;
    dstb_n = 1'b0;
    n = 0;
    while (!wait_o && n < 20) begin
      @(posedge clk_in); #1;
      n++;
    end
    chk("both_lat", n, 3);
    repeat (3) @(negedge clk_in);
    astb_n = 1'b1;
    dstb_n = 1'b1;
    n = 0;
    while (wait_o && n < 20) begin
      @(posedge clk_in); #1;
      n++;
    end
    repeat (3) @(negedge clk_in);
    wr_n = 1'b1;
    host_cycle(1'b1, 1'b0, 8'h00, rd, oe, lat, rel);
    chk("both_addr", rd, 8'h02);
    chk("both_led", led_o, 8'h3C);
    host_cycle(1'b1, 1'b1, 8'h00, rd, oe, lat, rel);
    host_cycle(1'b0, 1'b0, 8'h00, rd, oe, lat, rel);
    chk("both_scratch", rd, 8'h00);

    // Scratch and unmapped address
    host_cycle(1'b0, 1'b1, 8'h77, rd, oe, lat, rel);
    host_cycle(1'b1, 1'b1, 8'h05, rd, oe, lat, rel);
    host_cycle(1'b0, 1'b1, 8'h55, rd, oe, lat, rel);
    host_cycle(1'b0, 1'b0, 8'h00, rd, oe, lat, rel);
    chk("unmapped_rd", rd, 8'h00);
    host_cycle(1'b1, 1'b1, 8'h00, rd, oe, lat, rel);
    host_cycle(1'b0, 1'b0, 8'h00, rd, oe, lat, rel);
    chk("scratch_rd", rd, 8'h77);

    // Async reset during HOLD of an address read
    host_cycle(1'b1, 1'b1, 8'h01, rd, oe, lat, rel);
    host_cycle(1'b0, 1'b1, 8'hFF, rd, oe, lat, rel);
    chk("led_ff", led_o, 8'hFF);
    @(negedge clk_in);
    wr_n = 1'b1;
    @(negedge clk_in);
    astb_n = 1'b0;
    repeat (5) @(negedge clk_in);
    chk("hold_wait", wait_o, 1'b1);
    chk("hold_oe", db_oe, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wait", wait_o, 1'b0);
    chk("arst_oe", db_oe, 1'b0);
    chk("arst_db_o", db_o, 8'h00);
    chk("arst_led", led_o, 8'h00);
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (8) @(negedge clk_in);
    chk("no_replay", wait_o, 1'b0);
    astb_n = 1'b1;
    repeat (4) @(negedge clk_in);
    host_cycle(1'b1, 1'b0, 8'h00, rd, oe, lat, rel);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_addr", rd, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/epp_slave.md
EPP_SLAVE -- requirements
Module: epp_slave

Interface
REQ-001 Parameter ID_VALUE, default 8'hA5, constant returned on reads of register 0x03.
REQ-002 Parameter HB_WIDTH, default 8, heartbeat counter width; legal range 1..8; read value zero-extended to 8 bits.
REQ-003 clk_in  input  1  single system clock; every flop in the block is clocked on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset; assertion is immediate, deassertion is synchronous to clk_in.
REQ-005 slow_clk  input  1  slow divided clock from the clock divider; treated as data and sampled on clk_in, never used as a clock.
REQ-006 astb_n  input  1  EPP address strobe, active low, asynchronous to clk_in.
REQ-007 dstb_n  input  1  EPP data strobe, active low, asynchronous to clk_in.
REQ-008 wr_n  input  1  EPP write select; 0 = host write, 1 = host read.
REQ-009 db_i  input  8  EPP data bus, host to block.
REQ-010 db_o  output  8  EPP data bus, block to host.
REQ-011 db_oe  output  1  tristate enable for db_o; high only during a read cycle.
REQ-012 wait_o  output  1  EPP wait; high acknowledges the strobe currently active.
REQ-013 led_o  output  8  contents of the LED register.

Function
REQ-014 astb_n, dstb_n and wr_n shall each pass through a 2-flop synchronizer; reset value of every synchronizer flop is 1.
REQ-015 slow_clk shall pass through a 2-flop synchronizer plus one history flop; each synchronized 0->1 transition shall increment hb_cnt by 1, modulo 2^HB_WIDTH, with wrap from all-ones to 0.
REQ-016 FSM states: IDLE, ADDR_WR, ADDR_RD, DATA_WR, DATA_RD, HOLD.
REQ-017 IDLE, synced astb low: go to ADDR_WR if synced wr_n = 0, otherwise ADDR_RD.
REQ-018 IDLE, synced astb high and synced dstb low: go to DATA_WR if synced wr_n = 0, otherwise DATA_RD.
REQ-019 Both synced strobes low in the same cycle: the address strobe wins; the data strobe is ignored until it is seen low again from IDLE.
REQ-020 ADDR_WR: latch db_i into addr_reg; go to HOLD after one cycle.
REQ-021 DATA_WR: write db_i to the register selected by addr_reg; go to HOLD after one cycle.
REQ-022 ADDR_RD and DATA_RD: drive db_o and assert db_oe; go to HOLD after one cycle.
REQ-023 HOLD: keep wait_o = 1; on a read, keep db_o and db_oe stable.
REQ-024 HOLD exit: when the synced copy of the strobe that started the cycle returns high, go to IDLE; wait_o and db_oe drop on that transition.
REQ-025 wait_o shall be 1 in every state except IDLE.
REQ-026 Latency: the first cycle with wait_o = 1 is the 3rd rising edge of clk_in after a strobe falling edge (2 synchronizer edges + 1 FSM edge).
REQ-027 Register map:
  - 0x00: scratch, R/W.
  - 0x01: LED, R/W, drives led_o.
  - 0x02: hb_cnt, read-only.
  - 0x03: ID_VALUE, read-only.
  - Any other address reads 8'h00.
  - Writes to 0x02, 0x03 and unmapped addresses are ignored.
REQ-028 An address read returns addr_reg; a data read returns the register selected by addr_reg.
REQ-029 db_o shall be 8'h00 whenever db_oe = 0.
REQ-030 hb_cnt shall count in every FSM state, including during EPP cycles.

Reset
REQ-031 While rst_n = 0, and immediately on its assertion:
  - FSM = IDLE; wait_o = 0; db_oe = 0; db_o = 8'h00.
  - addr_reg = 0; scratch = 0; LED = 0 (so led_o = 8'h00); hb_cnt = 0.
REQ-032 Reset asserted during an EPP cycle shall abort that cycle; after release the FSM shall start no new cycle until the synced strobes have been seen high and then low again.

Verification
REQ-033 Host address write 0x01, then data write 0x3C -> led_o = 8'h3C; each strobe is acknowledged by wait_o rising 3 clk_in edges after the strobe falls.
REQ-034 Address write 0x03, then data read -> db_oe = 1 and db_o = 8'hA5 while wait_o = 1; db_oe and wait_o drop 2-3 clk_in edges after dstb_n rises.
REQ-035 Toggle slow_clk 260 times with HB_WIDTH = 8, then read address 0x02 -> 8'h04 (wrap-around).
REQ-036 Drive astb_n and dstb_n low on the same clk_in edge with wr_n = 0 and db_i = 8'h02 -> addr_reg = 8'h02; scratch and LED unchanged.
REQ-037 Data write 0x77 to address 0x00, then address 0x05 -> reading address 0x00 returns 8'h77 and reading address 0x05 returns 8'h00.
REQ-038 Pulse rst_n low while in HOLD with led_o = 8'hFF -> wait_o = 0, db_oe = 0 and led_o = 8'h00 within the same clk_in cycle, without waiting for a clock edge.
